edge_packer: RTL and testbench

- Downstream end of the 3x3 convolution stream: consumes one signed convolution result per input pixel, in raster order, over a valid/ready handshake.
- Discards the warm-up results produced while the line buffers and window fill (first two rows, first two columns of every row).
- Thresholds the absolute value of each kept result to a 1-bit edge flag.
- Packs flags LSB-first into out_width_p-bit words for the byte link back to the ESP, and marks the last word of each frame.

---
 rtl/edge_pkg.sv | 23 ++
 rtl/edge_packer_bit_packer.sv | 66 ++++++
 rtl/edge_packer.sv | 78 +++++++
 tb/tb_edge_packer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge flag packer.
// Default geometry, counter typedefs and the overflow-free magnitude function.
package edge_pkg;

    localparam int LINEWIDTH_PX = 16;
    localparam int FRAME_HEIGHT = 16;
    localparam int IN_WIDTH     = 32;
    localparam int OUT_WIDTH    = 8;

    typedef logic [$clog2(LINEWIDTH_PX)-1:0] col_t;
    typedef logic [$clog2(FRAME_HEIGHT)-1:0] row_t;
    typedef logic [$clog2(OUT_WIDTH)-1:0]    bitcnt_t;

    // One extra bit so the most negative input maps to +2^(IN_WIDTH-1).
    function automatic logic [IN_WIDTH:0] abs_mag(
        input logic signed [IN_WIDTH-1:0] v
    );
        logic [IN_WIDTH:0] ext;
        ext = {v[IN_WIDTH-1], v};
        return v[IN_WIDTH-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/edge_packer_bit_packer.sv
// Packs flags LSB-first into words and holds them in an elastic output register.
// Ports: flag_i/push_i add a bit, flush_i forces out a partial word, last_i tags it;
// valid_o/ready_i/data_o/last_o is the word stream, ready_o gates upstream accepts.
module bit_packer #(
    parameter int out_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flag_i,
    input  logic                   push_i,
    input  logic                   flush_i,
    input  logic                   last_i,
    output logic                   ready_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [out_width_p-1:0] data_o,
    output logic                   last_o
);

    localparam int BW = $clog2(out_width_p);

    logic [BW-1:0]          bitcnt_q;
    logic [out_width_p-1:0] shreg_q;
    logic [out_width_p-1:0] word;
    logic                   full;
    logic                   emit;

    always_comb begin
        word = shreg_q;
        if (push_i) begin
            word[bitcnt_q] = flag_i;
        end
    end

    // A full word on the frame's last beat is a single emit tagged last.
    assign full    = push_i && (bitcnt_q == BW'(out_width_p - 1));
    assign emit    = full || (flush_i && (push_i || (bitcnt_q != '0)));
    assign ready_o = ~valid_o | ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bitcnt_q <= '0;
            shreg_q  <= '0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            last_o   <= 1'b0;
        end else begin
            if (emit) begin
                bitcnt_q <= '0;
                shreg_q  <= '0;
            end else if (push_i) begin
                bitcnt_q <= bitcnt_q + 1'b1;
                shreg_q  <= word;
            end

            if (emit) begin
                valid_o <= 1'b1;
                data_o  <= word;
                last_o  <= last_i;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/edge_packer.sv
// Turns the raster stream of convolution results into packed edge-flag words.
// Ports: valid_i/ready_o/data_i result stream, threshold_i magnitude limit,
// valid_o/ready_i/data_o/last_o packed word stream (last_o marks end of frame).
module edge_packer
    import edge_pkg::*;
#(
    parameter int linewidth_px_p = 16,
    parameter int frame_height_p = 16,
    parameter int in_width_p     = IN_WIDTH,
    parameter int out_width_p    = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [in_width_p-1:0]  data_i,
    input  logic [in_width_p-1:0]  threshold_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [out_width_p-1:0] data_o,
    output logic                   last_o
);

    localparam int CW = $clog2(linewidth_px_p);
    localparam int RW = $clog2(frame_height_p);

    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic                accept;
    logic                col_end;
    logic                row_end;
    logic                eof;
    logic                keep;
    logic [in_width_p:0] mag;
    logic                flag;

    assign accept  = valid_i & ready_o;
    assign col_end = (col_q == CW'(linewidth_px_p - 1));
    assign row_end = (row_q == RW'(frame_height_p - 1));
    assign eof     = col_end & row_end;

    // The first two rows and columns are window warm-up results.
    assign keep = (row_q >= RW'(2)) && (col_q >= CW'(2));

    assign mag  = abs_mag(data_i);
    assign flag = (mag >= {1'b0, threshold_i});

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    bit_packer #(
        .out_width_p(out_width_p)
    ) u_packer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flag_i  (flag),
        .push_i  (accept & keep),
        .flush_i (accept & eof),
        .last_i  (eof),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .last_o  (last_o)
    );

endmodule

// File: tb/tb_edge_packer.sv
// Scoreboard bench for edge_packer on three frame geometries.
// Directed hand-computed frames plus a model-checked random-gap run.
module tb_edge_packer;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        v_i   [3];
    logic        rdy_o [3];
    logic [31:0] d_i   [3];
    logic [31:0] thr   [3];
    logic        vo    [3];
    logic        rdy_i [3];
    logic [7:0]  dout  [3];
    logic        lo    [3];

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    logic signed [31:0] fd [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    edge_packer #(.linewidth_px_p(4), .frame_height_p(4)) u_d4 (
        .clk_i(clk), .reset_i(rst[0]), .valid_i(v_i[0]), .ready_o(rdy_o[0]),
        .data_i(d_i[0]), .threshold_i(thr[0]), .valid_o(vo[0]),
        .ready_i(rdy_i[0]), .data_o(dout[0]), .last_o(lo[0]));

    edge_packer #(.linewidth_px_p(10), .frame_height_p(3)) u_d10 (
        .clk_i(clk), .reset_i(rst[1]), .valid_i(v_i[1]), .ready_o(rdy_o[1]),
        .data_i(d_i[1]), .threshold_i(thr[1]), .valid_o(vo[1]),
        .ready_i(rdy_i[1]), .data_o(dout[1]), .last_o(lo[1]));

    edge_packer #(.linewidth_px_p(16), .frame_height_p(16)) u_d16 (
        .clk_i(clk), .reset_i(rst[2]), .valid_i(v_i[2]), .ready_o(rdy_o[2]),
        .data_i(d_i[2]), .threshold_i(thr[2]), .valid_o(vo[2]),
        .ready_i(rdy_i[2]), .data_o(dout[2]), .last_o(lo[2]));

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(int i, logic [8:0] e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic mon(int i);
        logic [8:0] e;
        if (qsize(i) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word dut%0d: got last=%b data=%h, expected none",
                     i, lo[i], dout[i]);
        end else begin
            case (i)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("word_dut%0d", i), {23'b0, lo[i], dout[i]}, {23'b0, e});
        end
    endtask

    // Handshake completes on the next rising edge; check it at the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst[i] && vo[i] && rdy_i[i]) mon(i);
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int i, logic [31:0] d);
        int   b;
        logic acc;
        v_i[i] = 1'b1;
        d_i[i] = d;
        b = 0;
        do begin
            @(negedge clk);
            acc = rdy_o[i];
            @(posedge clk);
            #1;
            b++;
        end while (!acc && b < 500);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        v_i[i] = 1'b0;
    endtask

    task automatic send_frame(int i, int n, int gaps);
        for (int k = 0; k < n; k++) begin
            send(i, fd[k]);
            if (gaps != 0) cyc($urandom_range(0, 2));
        end
    endtask

    task automatic drain(int i);
        int b;
        b = 0;
        while (qsize(i) != 0 && b < 3000) begin
            cyc(1);
            b++;
        end
        chk($sformatf("drain_dut%0d", i), qsize(i), 0);
    endtask

    function automatic longint mag(logic signed [31:0] d);
        longint v;
        v = d;
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_frame(int i, int w, int h, logic [31:0] th);
        logic [7:0] bits;
        int         n;
        logic       eof;
        bits = 8'h00;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                eof = (r == h - 1) && (c == w - 1);
                if (r >= 2 && c >= 2) begin
                    bits[n] = (mag(fd[r*w+c]) >= longint'(th));
                    n++;
                end
                if (n == 8 || (eof && n > 0)) begin
                    push_exp(i, {eof, bits});
                    bits = 8'h00;
                    n = 0;
                end
            end
        end
    endtask

    task automatic push_ones_frame(int i);
        for (int k = 0; k < 24; k++) push_exp(i, {1'b0, 8'hFF});
        push_exp(i, {1'b1, 8'h0F});
    endtask

    task automatic stall_watch();
        int         b;
        logic [7:0] hd;
        logic       hl;
        b = 0;
        while (!vo[2] && b < 1000) begin
            @(negedge clk);
            b++;
        end
        chk("stall_seen", {31'b0, vo[2]}, 32'd1);
        hd = dout[2];
        hl = lo[2];
        chk("stall_word", {24'b0, hd}, 32'hFF);
        repeat (20) begin
            @(negedge clk);
            chk("stall_ready_o", {31'b0, rdy_o[2]}, 32'd0);
            chk("stall_data", {24'b0, dout[2]}, {24'b0, hd});
            chk("stall_last", {31'b0, lo[2]}, {31'b0, hl});
        end
        @(posedge clk);
        #1;
        rdy_i[2] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic done;
        for (int i = 0; i < 3; i++) begin
            rst[i]   = 1'b1;
            v_i[i]   = 1'b0;
            d_i[i]   = '0;
            thr[i]   = '0;
            rdy_i[i] = 1'b1;
        end
        cyc(3);
        for (int i = 0; i < 3; i++) begin
            chk("reset_valid_o", {31'b0, vo[i]}, 32'd0);
            chk("reset_data_o", {24'b0, dout[i]}, 32'd0);
            chk("reset_last_o", {31'b0, lo[i]}, 32'd0);
            chk("reset_ready_o", {31'b0, rdy_o[i]}, 32'd1);
        end
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        cyc(1);

        // 4x4 frame, four kept pixels: -7,3,5,-4 against 5 -> 0101.
        thr[0] = 32'd5;
        for (int k = 0; k < 16; k++) fd[k] = 32'sd100;
        fd[10] = -32'sd7;
        fd[11] = 32'sd3;
        fd[14] = 32'sd5;
        fd[15] = -32'sd4;
        push_exp(0, {1'b1, 8'h05});
        for (int k = 0; k < 16; k++) begin
            send(0, fd[k]);
            if (k == 14) chk("t1_no_early_word", {31'b0, vo[0]}, 32'd0);
        end
        chk("t1_latency", {31'b0, vo[0]}, 32'd1);
        drain(0);

        // 10x3 frame: 8 kept pixels fill one word exactly at end of frame.
        thr[1] = 32'd0;
        push_exp(1, {1'b1, 8'hFF});
        for (int k = 0; k < 30; k++) send(1, k);
        drain(1);
        cyc(5);
        chk("t3_no_extra_word", {31'b0, vo[1]}, 32'd0);

        // 16x16 most-negative input against 2^31: 196 ones.
        thr[2] = 32'h8000_0000;
        for (int k = 0; k < 256; k++) fd[k] = 32'sh8000_0000;
        push_ones_frame(2);
        send_frame(2, 256, 0);
        drain(2);

        // Downstream stall on the first word, then two back-to-back frames.
        rdy_i[2] = 1'b0;
        push_ones_frame(2);
        push_ones_frame(2);
        fork
            begin
                send_frame(2, 256, 0);
                send_frame(2, 256, 0);
            end
            stall_watch();
        join
        drain(2);

        // Random input and output gaps over three frames.
        thr[2] = 32'd10;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int k = 0; k < 256; k++)
                        fd[k] = $signed($urandom_range(0, 40)) - 20;
                    model_frame(2, 16, 16, thr[2]);
                    send_frame(2, 256, 1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    cyc(1);
                    rdy_i[2] = ($urandom_range(0, 3) != 0);
                end
                rdy_i[2] = 1'b1;
            end
        join
        drain(2);

        // Async reset with a word pending, then a clean frame.
        thr[2] = 32'h8000_0000;
        rdy_i[2] = 1'b0;
        for (int k = 0; k < 42; k++) send(2, 32'h8000_0000);
        chk("rst_word_pending", {31'b0, vo[2]}, 32'd1);
        #3;
        rst[2] = 1'b1;
        #1;
        chk("rst_async_valid", {31'b0, vo[2]}, 32'd0);
        chk("rst_async_last", {31'b0, lo[2]}, 32'd0);
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        rdy_i[2] = 1'b1;
        for (int k = 0; k < 256; k++) fd[k] = 32'sh8000_0000;
        push_ones_frame(2);
        send_frame(2, 256, 0);
        drain(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
